// File: rtl/pll_reset_sequencer.sv
// PLL power-up/recovery sequencer: pulses the PLL reset, qualifies the synchronized
// lock flag and holds the core reset until the clocks have been stable long enough.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int SOFT_CYCLES   = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lost_count
);

  // A synchronizer shorter than two flops gives no metastability protection.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = (SETTLE_CYCLES > SOFT_CYCLES) ? SETTLE_CYCLES : SOFT_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P + 1);

  // Each state counts down from N-1 and acts on the edge that finds zero.
  localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SOFT_LD   = CW'(SOFT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_SOFT      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        retry_q, retry_d;
  logic [7:0]        lost_q, lost_d;
  logic [SYNC_N-1:0] sync_q;
  logic              locked_s;
  logic              cnt_zero;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_reset_q, sys_reset_d;
  logic              ready_q, ready_d;

  assign locked_s = sync_q[SYNC_N-1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= RST_LD;
      retry_q     <= 8'd0;
      lost_q      <= 8'd0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync_q      <= {sync_q[SYNC_N-2:0], pll_locked};
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_zero) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LOCK_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (cnt_zero) begin
          state_d = S_RESET_PLL;
          cnt_d   = RST_LD;
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LOCK_LD;
        end else if (cnt_zero) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        // Loss of lock outranks a coincident soft request.
        if (!locked_s) begin
          state_d = S_RESET_PLL;
          cnt_d   = RST_LD;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (soft_req) begin
          state_d = S_SOFT;
          cnt_d   = SOFT_LD;
        end
      end
      S_SOFT: begin
        if (!locked_s) begin
          state_d = S_RESET_PLL;
          cnt_d   = RST_LD;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (cnt_zero) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = RST_LD;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they move with the state.
  always_comb begin
    pll_rst_d   = (state_d == S_RESET_PLL);
    ready_d     = (state_d == S_RUN);
    sys_reset_d = ~ready_d;
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-up and recovery sequencer for the system PLL that generates the 57.27/28.64/114.55/14.32 MHz clocks from the 50 MHz board reference. It runs on the free-running reference clock and drives the PLL reset. It qualifies the PLL `locked` flag and holds the downstream system reset until the clocks are stable. On loss of lock it re-arms the PLL and re-applies system reset. It also provides a soft-reset path that resets the core without disturbing the PLL.

## Interface
Parameters:
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per PLL reset attempt.
- `LOCK_TIMEOUT`, 65536: refclk cycles to wait for lock before a retry.
- `SETTLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `SOFT_CYCLES`, 64: `sys_reset` pulse length for a soft reset.
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; minimum 2.

Ports:
- `refclk` input 1: 50 MHz free-running reference clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pll_locked` input 1: PLL lock flag; asynchronous to `refclk`.
- `soft_req` input 1: synchronous single-cycle soft-reset request.
- `pll_rst` output 1: active-high PLL reset.
- `sys_reset` output 1: active-high reset to the core logic.
- `ready` output 1: high only in RUN.
- `state` output 3: current state, for debug.
- `retry_count` output 8: number of lock timeouts; saturates at 255.
- `lost_count` output 8: number of lock losses after release; saturates at 255.

## Operation
- The synchronizer produces `locked_s`, the output of the last synchronizer flop. The FSM uses only `locked_s`.
- A single down-counter is shared by all states. Its width covers the largest parameter.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, RUN=3, SOFT=4.
- **RESET_PLL**: `pll_rst`=1, `sys_reset`=1. After `RST_CYCLES` edges, go to WAIT_LOCK and set `pll_rst`=0.
- **WAIT_LOCK**:
  - If `locked_s`=1, go to SETTLE.
  - Otherwise, after `LOCK_TIMEOUT` edges, go to RESET_PLL and increment `retry_count`.
- **SETTLE**:
  - If `locked_s`=0, go back to WAIT_LOCK with a fresh timeout.
  - After `SETTLE_CYCLES` consecutive edges with `locked_s`=1, go to RUN.
- **RUN**: `sys_reset`=0, `ready`=1.
  - If `locked_s`=0, go to RESET_PLL and increment `lost_count`.
  - Else if `soft_req`=1, go to SOFT.
- **SOFT**: `sys_reset`=1, `ready`=0, `pll_rst`=0.
  - If `locked_s`=0, go to RESET_PLL and increment `lost_count`.
  - Otherwise, after `SOFT_CYCLES` edges, return to RUN.
- Loss of lock has priority over `soft_req` on the same edge.
- `soft_req` is ignored in every state except RUN, and while in SOFT. It does not extend the pulse.
- Both counters saturate at 255 and never wrap. They are cleared only by `rst_n`.

## Timing
- All outputs are registered and change only on `refclk` rising edges, except on async reset.
- Values while `rst_n`=0:
  - `pll_rst`=1, `sys_reset`=1, `ready`=0.
  - `state`=0, `retry_count`=0, `lost_count`=0.
  - Synchronizer flops cleared.
- After `rst_n` deasserts, `pll_rst` stays high for exactly `RST_CYCLES` edges.
- Lock acquisition latency: `pll_locked` rises before edge 1 → `locked_s`=1 after edge `SYNC_STAGES` → SETTLE at edge `SYNC_STAGES`+1 → `sys_reset` falls and `ready` rises together at edge `SYNC_STAGES`+1+`SETTLE_CYCLES`.
- Lock loss latency: `pll_locked` falls → `sys_reset`=1, `ready`=0, `pll_rst`=1 at edge `SYNC_STAGES`+1.
- Soft reset: `soft_req` sampled at edge N → `sys_reset`=1 from edge N through edge N+`SOFT_CYCLES`-1 → `sys_reset`=0 at edge N+`SOFT_CYCLES`.
- `sys_reset` and `ready` are always complementary.
- `pll_rst`=1 only in RESET_PLL.
- If `rst_n` asserts mid-operation, outputs go immediately to their reset values, even in the middle of a count.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `SETTLE_CYCLES`=8, `SOFT_CYCLES`=5, `SYNC_STAGES`=2.
- Clean bring-up:
  - Release `rst_n`; `pll_rst` is high for 4 edges.
  - Raise `pll_locked` 10 cycles later; `ready`=1 and `sys_reset`=0 exactly 11 edges after the rise.
- Timeout retry:
  - Hold `pll_locked`=0.
  - `pll_rst` re-pulses for 4 edges every 36 edges; `retry_count` increments 1, 2, 3.
  - After 300 attempts, `retry_count` is 255 (saturated).
- Settle glitch:
  - Raise `pll_locked`, drop it for 3 cycles after 5 cycles, then raise it again.
  - State returns to WAIT_LOCK, `ready` stays 0, `retry_count` is unchanged.
  - `ready` rises 11 edges after the second rise.
- Lock loss in RUN:
  - Drop `pll_locked`; `sys_reset`=1 and `pll_rst`=1 at edge 3.
  - `lost_count`=1, and full re-acquisition follows.
- Soft reset:
  - In RUN, pulse `soft_req`; `sys_reset` is high exactly 5 edges and `pll_rst` stays 0.
  - A second `soft_req` during SOFT has no effect.
  - `soft_req` coincident with lock loss → RESET_PLL and `lost_count`+1.
- Mid-operation reset:
  - Assert `rst_n`=0 in SETTLE and during SOFT.
  - Outputs return to their reset values with no clock edge, and both counters read 0.
